// File: rtl/hmc_reorder_buf.sv
// ---------------------------------------------------------------------------
// hmc_reorder_buf
//
// Reorder buffer for HMC read responses. Requests are registered on the issue
// side (tag + beat count) and each tag reserves a contiguous, wrapping range of
// the beat RAM. Responses may arrive in any tag order and are written straight
// into that range. The drain side walks tags in issue order. A tag is sent out
// only once all of its beats have landed, one beat per cycle.
//
// Optional feature macro: HMC_REORDER_TIMEOUT_EN
//   When defined, a watchdog aborts a stalled head tag after TIMEOUT cycles.
//   Its missing beats are then emitted as data=0, dinv=1, errstat=7'h7F.
//   When undefined, the head waits indefinitely and timeout_err is tied 0.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   issue_valid/ready/tag/beats  issue handshake; beats==0 is accepted silently
//   rsp_valid/tag/data/errstat/dinv  response beats; never stalled
//   out_valid/ready/tag/data/errstat/dinv/last  ordered beat stream
//   free_beats                unreserved RAM entries
//   err_unexpect              sticky: dropped (unexpected) response beat
//   timeout_err               sticky: watchdog fired
// ---------------------------------------------------------------------------
module hmc_reorder_buf #(
  parameter int ID_WIDTH   = 6,
  parameter int DATA_WIDTH = 128,
  parameter int MAX_BEATS  = 8,
  parameter int DEPTH_LOG2 = 9,
  parameter int TIMEOUT    = 4096,
  parameter int BEATS_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [ID_WIDTH-1:0]   issue_tag,
  input  logic [BEATS_W-1:0]    issue_beats,
  input  logic                  rsp_valid,
  input  logic [ID_WIDTH-1:0]   rsp_tag,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic [6:0]            rsp_errstat,
  input  logic                  rsp_dinv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ID_WIDTH-1:0]   out_tag,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [6:0]            out_errstat,
  output logic                  out_dinv,
  output logic                  out_last,
  output logic [DEPTH_LOG2:0]   free_beats,
  output logic                  err_unexpect,
  output logic                  timeout_err
);

  localparam int NTAGS = 1 << ID_WIDTH;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int RAM_W = DATA_WIDTH + 8;

  if ((DEPTH < MAX_BEATS) || (TIMEOUT < 1)) begin : g_bad_params
    $error("hmc_reorder_buf: RAM depth must hold MAX_BEATS and TIMEOUT must be positive");
  end

  // Per-tag tables
  logic                  pending_q   [NTAGS];
  logic                  abort_q     [NTAGS];
  logic [DEPTH_LOG2-1:0] tag_base_q  [NTAGS];
  logic [BEATS_W-1:0]    tag_beats_q [NTAGS];
  logic [BEATS_W-1:0]    wr_cnt_q    [NTAGS];

  // Order FIFO: wptr pushes, rptr is the tag being read, pptr is the tag
  // being handed to the consumer. Splitting read and pop lets the next tag
  // start reading while the previous tag's last beat waits in the output stage.
  logic [ID_WIDTH-1:0]   fifo_q [NTAGS];
  logic [ID_WIDTH:0]     wptr_q, rptr_q, pptr_q;
  logic [ID_WIDTH:0]     fifo_cnt;

  logic                  rdy_en_q;
  logic [DEPTH_LOG2-1:0] alloc_q;
  logic [DEPTH_LOG2:0]   free_q, free_d;
  logic [BEATS_W-1:0]    rd_idx_q;
  logic                  err_unexp_q;

  logic [RAM_W-1:0]      mem [DEPTH];

  logic                  out_valid_q, out_last_q, out_miss_q;
  logic [ID_WIDTH-1:0]   out_tag_q;
  logic [RAM_W-1:0]      out_ram_q;

  logic                  to_fire;

  // ---------------- issue side ----------------
  logic [DEPTH_LOG2:0] issue_beats_x;
  logic                issue_fire, issue_push, fifo_full;

  assign issue_beats_x = (DEPTH_LOG2 + 1)'(issue_beats);
  assign fifo_cnt      = wptr_q - pptr_q;
  // Occupancy never exceeds NTAGS, so the MSB alone marks full.
  assign fifo_full     = fifo_cnt[ID_WIDTH];
  assign issue_ready   = rdy_en_q & ~pending_q[issue_tag] & (free_q >= issue_beats_x) & ~fifo_full;
  assign issue_fire    = issue_valid & issue_ready;
  assign issue_push    = issue_fire & (issue_beats != '0);

  // ---------------- response side ----------------
  logic                  rsp_ok, rsp_drop;
  logic [DEPTH_LOG2-1:0] wr_addr;

  assign rsp_ok   = rsp_valid & pending_q[rsp_tag] & ~abort_q[rsp_tag] &
                    (wr_cnt_q[rsp_tag] != tag_beats_q[rsp_tag]);
  assign rsp_drop = rsp_valid & ~rsp_ok;
  assign wr_addr  = tag_base_q[rsp_tag] + DEPTH_LOG2'(wr_cnt_q[rsp_tag]);

  // ---------------- drain side ----------------
  logic                  rd_vld, rd_complete, rd_go, rd_last, rd_miss, out_pop;
  logic [ID_WIDTH-1:0]   rd_tag;
  logic [BEATS_W-1:0]    rd_beats, rd_beats_m1, rd_wr;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [DEPTH_LOG2:0]   freed, reserved;

  assign rd_vld      = (rptr_q != wptr_q);
  assign rd_tag      = fifo_q[rptr_q[ID_WIDTH-1:0]];
  assign rd_beats    = tag_beats_q[rd_tag];
  assign rd_beats_m1 = rd_beats - 1'b1;
  assign rd_wr       = wr_cnt_q[rd_tag];
  assign rd_complete = (rd_wr == rd_beats) | abort_q[rd_tag];
  assign rd_go       = rd_vld & rd_complete & (~out_valid_q | out_ready);
  assign rd_last     = (rd_idx_q == rd_beats_m1);
  // Beats land in order, so after an abort every index at or beyond the
  // frozen write count is a beat that never arrived.
  assign rd_miss     = abort_q[rd_tag] & (rd_idx_q >= rd_wr);
  assign rd_addr     = tag_base_q[rd_tag] + DEPTH_LOG2'(rd_idx_q);
  assign out_pop     = out_valid_q & out_ready & out_last_q;

  assign freed    = out_pop ? (DEPTH_LOG2 + 1)'(tag_beats_q[out_tag_q]) : '0;
  assign reserved = issue_push ? issue_beats_x : '0;
  assign free_d   = free_q + freed - reserved;

  // ---------------- watchdog ----------------
`ifdef HMC_REORDER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            to_run, head_hit, timeout_q;

  assign to_run   = rd_vld & ~rd_complete;
  assign head_hit = rsp_ok & (rsp_tag == rd_tag);
  assign to_fire  = to_run & (to_cnt_q == TO_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!to_run || head_hit || to_fire) to_cnt_q <= '0;
      else                                to_cnt_q <= to_cnt_q + 1'b1;
      if (to_fire) timeout_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign to_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // ---------------- tag tables ----------------
  // Same-tag collisions between the branches below cannot occur: issue needs
  // the tag not pending, responses need it pending, and the popped tag has
  // already been fully read so it is never the aborted read-side head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAGS; i++) begin
        pending_q[i]   <= 1'b0;
        abort_q[i]     <= 1'b0;
        tag_base_q[i]  <= '0;
        tag_beats_q[i] <= '0;
        wr_cnt_q[i]    <= '0;
        fifo_q[i]      <= '0;
      end
    end else begin
      if (rsp_ok) wr_cnt_q[rsp_tag] <= wr_cnt_q[rsp_tag] + 1'b1;
      if (issue_push) begin
        tag_base_q[issue_tag]          <= alloc_q;
        tag_beats_q[issue_tag]         <= issue_beats;
        wr_cnt_q[issue_tag]            <= '0;
        pending_q[issue_tag]           <= 1'b1;
        fifo_q[wptr_q[ID_WIDTH-1:0]]   <= issue_tag;
      end
      if (to_fire) abort_q[rd_tag] <= 1'b1;
      if (out_pop) begin
        pending_q[out_tag_q] <= 1'b0;
        abort_q[out_tag_q]   <= 1'b0;
      end
    end
  end

  // ---------------- pointers and counters ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en_q    <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      pptr_q      <= '0;
      alloc_q     <= '0;
      free_q      <= (DEPTH_LOG2 + 1)'(DEPTH);
      rd_idx_q    <= '0;
      err_unexp_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      free_q   <= free_d;
      if (issue_push) begin
        wptr_q  <= wptr_q + 1'b1;
        alloc_q <= alloc_q + DEPTH_LOG2'(issue_beats);
      end
      if (rd_go) begin
        if (rd_last) begin
          rd_idx_q <= '0;
          rptr_q   <= rptr_q + 1'b1;
        end else begin
          rd_idx_q <= rd_idx_q + 1'b1;
        end
      end
      if (out_pop)  pptr_q      <= pptr_q + 1'b1;
      if (rsp_drop) err_unexp_q <= 1'b1;
    end
  end

  // ---------------- beat RAM write ----------------
  always_ff @(posedge clk) begin
    if (rsp_ok) mem[wr_addr] <= {rsp_dinv, rsp_errstat, rsp_data};
  end

  // ---------------- registered read / output stage ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_miss_q  <= 1'b0;
      out_tag_q   <= '0;
      out_ram_q   <= '0;
    end else if (rd_go) begin
      out_valid_q <= 1'b1;
      out_last_q  <= rd_last;
      out_miss_q  <= rd_miss;
      out_tag_q   <= rd_tag;
      out_ram_q   <= mem[rd_addr];
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_tag      = out_tag_q;
  assign out_last     = out_last_q;
  assign out_data     = out_miss_q ? '0      : out_ram_q[DATA_WIDTH-1:0];
  assign out_errstat  = out_miss_q ? 7'h7F   : out_ram_q[DATA_WIDTH+6:DATA_WIDTH];
  assign out_dinv     = out_miss_q ? 1'b1    : out_ram_q[RAM_W-1];
  assign free_beats   = free_q;
  assign err_unexpect = err_unexp_q;

endmodule

// File: tb/tb_hmc_reorder_buf.sv
`define CHK(n, o, e) check(n, 64'(o), 64'(e))

module tb_hmc_reorder_buf;
  localparam int IDW = 6;
  localparam int DW  = 32;
  localparam int MB  = 8;
  localparam int DL2 = 4;
  localparam int TO  = 16;
  localparam int BW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid, issue_ready;
  logic [IDW-1:0]  issue_tag;
  logic [BW-1:0]   issue_beats;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_tag;
  logic [DW-1:0]   rsp_data;
  logic [6:0]      rsp_errstat;
  logic            rsp_dinv;
  logic            out_valid, out_ready;
  logic [IDW-1:0]  out_tag;
  logic [DW-1:0]   out_data;
  logic [6:0]      out_errstat;
  logic            out_dinv, out_last;
  logic [DL2:0]    free_beats;
  logic            err_unexpect, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hmc_reorder_buf #(
    .ID_WIDTH(IDW), .DATA_WIDTH(DW), .MAX_BEATS(MB), .DEPTH_LOG2(DL2), .TIMEOUT(TO), .BEATS_W(BW)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag), .issue_beats(issue_beats),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_errstat(rsp_errstat), .rsp_dinv(rsp_dinv),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
    .out_errstat(out_errstat), .out_dinv(out_dinv), .out_last(out_last),
    .free_beats(free_beats), .err_unexpect(err_unexpect), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [IDW-1:0] tag, input logic [BW-1:0] beats);
    issue_valid = 1'b1;
    issue_tag   = tag;
    issue_beats = beats;
    #1;
    `CHK("issue_ready at issue", issue_ready, 1);
    step();
    issue_valid = 1'b0;
  endtask

  task automatic rsp(input logic [IDW-1:0] tag, input logic [DW-1:0] data,
                     input logic [6:0] es, input logic dv);
    rsp_valid   = 1'b1;
    rsp_tag     = tag;
    rsp_data    = data;
    rsp_errstat = es;
    rsp_dinv    = dv;
    step();
    rsp_valid   = 1'b0;
  endtask

  task automatic expect_out(input string n, input logic [IDW-1:0] tag, input logic [DW-1:0] data,
                            input logic [6:0] es, input logic dv, input logic last);
    `CHK({n, " valid"},   out_valid,   1);
    `CHK({n, " tag"},     out_tag,     tag);
    `CHK({n, " data"},    out_data,    data);
    `CHK({n, " errstat"}, out_errstat, es);
    `CHK({n, " dinv"},    out_dinv,    dv);
    `CHK({n, " last"},    out_last,    last);
  endtask

  task automatic wait_out(input string n, input int max);
    int k = 0;
    while (!out_valid && k < max) begin
      step();
      k++;
    end
    `CHK({n, " wait out_valid"}, out_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [IDW-1:0] etag [3];
    logic [DW-1:0]  edat [3];
    logic           elast[3];
    int idx;

    rst = 1'b1; issue_valid = 1'b0; issue_tag = '0; issue_beats = '0;
    rsp_valid = 1'b0; rsp_tag = '0; rsp_data = '0; rsp_errstat = '0; rsp_dinv = 1'b0;
    out_ready = 1'b1;
    step(); step();

    // Reset state
    checks++;
    if (out_valid !== 1'b0) begin errors++; $error("FAIL rst out_valid: %0h", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $error("FAIL rst out_data: %0h", out_data); end
    checks++;
    if (out_last !== 1'b0) begin errors++; $error("FAIL rst out_last: %0h", out_last); end
    checks++;
    if (free_beats !== 5'd16) begin errors++; $error("FAIL rst free_beats: %0h", free_beats); end
    checks++;
    if (issue_ready !== 1'b0) begin errors++; $error("FAIL rst issue_ready: %0h", issue_ready); end
    checks++;
    if (err_unexpect !== 1'b0) begin errors++; $error("FAIL rst err_unexpect: %0h", err_unexpect); end
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $error("FAIL rst timeout_err: %0h", timeout_err); end
    rst = 1'b0;
    #1;
    `CHK("issue_ready before first edge", issue_ready, 0);
    step();
    `CHK("issue_ready after first edge", issue_ready, 1);

    // T1: single beat, latency and free-count return
    issue(6'd3, 4'd1);
    `CHK("T1 free after issue", free_beats, 15);
    rsp(6'd3, 32'hD0D0_0001, 7'h00, 1'b0);
    `CHK("T1 out_valid one cycle after write", out_valid, 0);
    step();
    expect_out("T1 beat", 6'd3, 32'hD0D0_0001, 7'h00, 1'b0, 1'b1);
    step();
    `CHK("T1 drained", out_valid, 0);
    `CHK("T1 free restored", free_beats, 16);

    // T2: out-of-order completion, back-to-back drain
    issue(6'd3, 4'd2);
    issue(6'd5, 4'd1);
    `CHK("T2 free reserved", free_beats, 13);
    rsp(6'd5, 32'hB000_0000, 7'h15, 1'b1);
    rsp(6'd3, 32'hA000_0000, 7'h00, 1'b0);
    rsp(6'd3, 32'hA000_0001, 7'h01, 1'b0);
    `CHK("T2 not yet valid", out_valid, 0);
    step();
    expect_out("T2 A0", 6'd3, 32'hA000_0000, 7'h00, 1'b0, 1'b0);
    step();
    expect_out("T2 A1", 6'd3, 32'hA000_0001, 7'h01, 1'b0, 1'b1);
    step();
    expect_out("T2 B0", 6'd5, 32'hB000_0000, 7'h15, 1'b1, 1'b1);
    step();
    `CHK("T2 drained", out_valid, 0);
    `CHK("T2 free restored", free_beats, 16);

    // T3: same traffic with out_ready toggling
    etag[0] = 6'd3; edat[0] = 32'hC000_0000; elast[0] = 1'b0;
    etag[1] = 6'd3; edat[1] = 32'hC000_0001; elast[1] = 1'b1;
    etag[2] = 6'd5; edat[2] = 32'hE000_0000; elast[2] = 1'b1;
    issue(6'd3, 4'd2);
    issue(6'd5, 4'd1);
    rsp(6'd5, 32'hE000_0000, 7'h00, 1'b0);
    rsp(6'd3, 32'hC000_0000, 7'h00, 1'b0);
    rsp(6'd3, 32'hC000_0001, 7'h00, 1'b0);
    idx = 0;
    for (int cyc = 0; cyc < 30 && idx < 3; cyc++) begin
      out_ready = cyc[0];
      if (out_valid) begin
        checks++;
        if (out_tag !== etag[idx]) begin
          errors++; $error("FAIL T3 tag: %0h expected %0h", out_tag, etag[idx]);
        end
        checks++;
        if (out_data !== edat[idx]) begin
          errors++; $error("FAIL T3 data: %0h expected %0h", out_data, edat[idx]);
        end
        checks++;
        if (out_last !== elast[idx]) begin
          errors++; $error("FAIL T3 last: %0h expected %0h", out_last, elast[idx]);
        end
        if (out_ready) idx++;
      end
      step();
    end
    out_ready = 1'b1;
    `CHK("T3 beats accepted", idx, 3);
    `CHK("T3 no duplicate", out_valid, 0);
    step();
    `CHK("T3 free restored", free_beats, 16);

    // T4: RAM exhaustion blocks issue until the first tag drains (wraps RAM)
    issue(6'd10, 4'd8);
    issue(6'd11, 4'd8);
    `CHK("T4 free zero", free_beats, 0);
    issue_tag = 6'd12; issue_beats = 4'd1;
    #1;
    `CHK("T4 issue blocked", issue_ready, 0);
    for (int i = 0; i < 8; i++) rsp(6'd10, 32'h100 + i, 7'h00, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      expect_out("T4 tag10", 6'd10, 32'h100 + i, 7'h00, 1'b0, (i == 7));
      `CHK("T4 ready held low", issue_ready, 0);
      step();
    end
    `CHK("T4 ready after release", issue_ready, 1);
    `CHK("T4 free after release", free_beats, 8);
    for (int i = 0; i < 8; i++) rsp(6'd11, 32'h200 + i, 7'h00, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      expect_out("T4 tag11", 6'd11, 32'h200 + i, 7'h00, 1'b0, (i == 7));
      step();
    end
    `CHK("T4 drained", out_valid, 0);
    `CHK("T4 free restored", free_beats, 16);

    // T5: response to a never-issued tag
    `CHK("T5 err before", err_unexpect, 0);
    rsp(6'd9, 32'h0000_0BAD, 7'h00, 1'b0);
    `CHK("T5 err set", err_unexpect, 1);
    step(); step();
    `CHK("T5 no output", out_valid, 0);
    `CHK("T5 free untouched", free_beats, 16);
    issue(6'd9, 4'd1);
    rsp(6'd9, 32'h0000_900D, 7'h02, 1'b0);
    step();
    expect_out("T5 later traffic", 6'd9, 32'h0000_900D, 7'h02, 1'b0, 1'b1);
    step();
    `CHK("T5 err sticky", err_unexpect, 1);

    // Reset mid-operation discards state
    issue(6'd20, 4'd2);
    rsp(6'd20, 32'h0000_0020, 7'h00, 1'b0);
    `CHK("mid free before reset", free_beats, 14);
    rst = 1'b1;
    step();
    `CHK("mid reset free", free_beats, 16);
    `CHK("mid reset err", err_unexpect, 0);
    `CHK("mid reset ready", issue_ready, 0);
    `CHK("mid reset out_valid", out_valid, 0);
    rst = 1'b0;
    step();
    `CHK("mid reset tag free again", issue_ready, 1);

    // Beat beyond the expected count is dropped
    issue(6'd20, 4'd1);
    out_ready = 1'b0;
    rsp(6'd20, 32'h0000_0011, 7'h00, 1'b0);
    rsp(6'd20, 32'h0000_0022, 7'h00, 1'b0);
    `CHK("extra beat err", err_unexpect, 1);
    expect_out("extra beat first", 6'd20, 32'h0000_0011, 7'h00, 1'b0, 1'b1);
    step();
    expect_out("extra beat held", 6'd20, 32'h0000_0011, 7'h00, 1'b0, 1'b1);
    out_ready = 1'b1;
    step();
    `CHK("extra beat no dup", out_valid, 0);
    `CHK("extra beat free", free_beats, 16);

`ifdef HMC_REORDER_TIMEOUT_EN
    // T6: watchdog aborts an incomplete head
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    issue(6'd2, 4'd2);
    rsp(6'd2, 32'h0000_00A5, 7'h03, 1'b0);
    for (int i = 0; i < 10; i++) step();
    `CHK("T6 still waiting", out_valid, 0);
    `CHK("T6 no timeout yet", timeout_err, 0);
    wait_out("T6", 40);
    expect_out("T6 beat0", 6'd2, 32'h0000_00A5, 7'h03, 1'b0, 1'b0);
    `CHK("T6 timeout_err", timeout_err, 1);
    step();
    expect_out("T6 beat1", 6'd2, 32'h0, 7'h7F, 1'b1, 1'b1);
    step();
    `CHK("T6 drained", out_valid, 0);
    `CHK("T6 err before late", err_unexpect, 0);
    rsp(6'd2, 32'h0000_0077, 7'h00, 1'b0);
    `CHK("T6 late beat err", err_unexpect, 1);
    `CHK("T6 free restored", free_beats, 16);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
